// File: rtl/int_sequencer.sv
// int_sequencer: interrupt entry (drain, push PC/flags, vector fetch) and RTI return (pop flags/PC); optional INT_MASK_EN adds an interrupt enable.
// Latency: Int edge -> PcLoad 6 cycles, RtiReq -> PcLoad 3 cycles, with zero-wait memory and a drained pipe.
// Backpressure: each memory step holds its request stable until MemAck; DRAIN waits on PipeDrained.
module int_sequencer #(
    parameter int          PC_W     = 32,
    parameter logic [15:0] VEC_ADDR = 16'h0002,
    parameter int          FLG_W    = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Int,
    input  logic             RtiReq,
    input  logic             PipeDrained,
    input  logic [PC_W-1:0]  PcIn,
    input  logic [FLG_W-1:0] FlagsIn,
    input  logic [15:0]      SpIn,
    input  logic             MemAck,
    input  logic [15:0]      MemRData,
`ifdef INT_MASK_EN
    input  logic             IntEnSet,
    input  logic             IntEnClr,
    output logic             IntEn,
`endif
    output logic             Busy,
    output logic             FlushIFID,
    output logic             MemReq,
    output logic             MemWe,
    output logic [15:0]      MemAddr,
    output logic [15:0]      MemWData,
    output logic             SpWe,
    output logic [15:0]      SpNext,
    output logic             PcLoad,
    output logic [PC_W-1:0]  PcOut,
    output logic             FlagsLoad,
    output logic [FLG_W-1:0] FlagsOut
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DRAIN,
        S_PUSH_HI,
        S_PUSH_LO,
        S_PUSH_FLG,
        S_VEC_RD,
        S_POP_FLG,
        S_POP_LO,
        S_POP_HI
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             int_q;
    logic             pending;
    logic             svc_ok;
    logic             take;
    logic             pop_hi_ack;
    logic [PC_W-1:0]  pc_q;
    logic [FLG_W-1:0] flg_q;
    logic [15:0]      lo_q;
    logic [15:0]      hi_word;
    logic [15:0]      flg_word;

    assign take       = (state == S_IDLE) && !RtiReq && pending && svc_ok;
    assign pop_hi_ack = (state == S_POP_HI) && MemAck;

`ifdef INT_MASK_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            IntEn <= 1'b1;
        end else if (IntEnSet) begin
            IntEn <= 1'b1;
        end else if (IntEnClr || take) begin
            IntEn <= 1'b0;
        end else if (pop_hi_ack) begin
            IntEn <= 1'b1;
        end
    end
    assign svc_ok = IntEn;
`else
    assign svc_ok = 1'b1;
`endif

    // A new edge in the same cycle the old request is taken stays latched.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            int_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            int_q   <= Int;
            pending <= (pending && !take) || (Int && !int_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q  <= '0;
            flg_q <= '0;
            lo_q  <= '0;
        end else begin
            if (state == S_DRAIN && PipeDrained) begin
                pc_q  <= PcIn;
                flg_q <= FlagsIn;
            end
            if (state == S_POP_FLG && MemAck) begin
                flg_q <= MemRData[FLG_W-1:0];
            end
            if (state == S_POP_LO && MemAck) begin
                lo_q <= MemRData;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (RtiReq) begin
                    state_nxt = S_POP_FLG;
                end else if (pending && svc_ok) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN:    if (PipeDrained) state_nxt = S_PUSH_HI;
            S_PUSH_HI:  if (MemAck)      state_nxt = S_PUSH_LO;
            S_PUSH_LO:  if (MemAck)      state_nxt = S_PUSH_FLG;
            S_PUSH_FLG: if (MemAck)      state_nxt = S_VEC_RD;
            S_VEC_RD:   if (MemAck)      state_nxt = S_IDLE;
            S_POP_FLG:  if (MemAck)      state_nxt = S_POP_LO;
            S_POP_LO:   if (MemAck)      state_nxt = S_POP_HI;
            S_POP_HI:   if (MemAck)      state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        hi_word              = '0;
        hi_word[PC_W-17:0]   = pc_q[PC_W-1:16];
        flg_word             = '0;
        flg_word[FLG_W-1:0]  = flg_q;
    end

    always_comb begin
        Busy      = (state != S_IDLE);
        FlushIFID = 1'b0;
        MemReq    = 1'b0;
        MemWe     = 1'b0;
        MemAddr   = '0;
        MemWData  = '0;
        SpWe      = 1'b0;
        SpNext    = '0;
        PcLoad    = 1'b0;
        PcOut     = '0;
        FlagsLoad = 1'b0;
        FlagsOut  = '0;
        case (state)
            S_IDLE: FlushIFID = take;
            S_PUSH_HI, S_PUSH_LO, S_PUSH_FLG: begin
                MemReq  = 1'b1;
                MemWe   = 1'b1;
                MemAddr = SpIn;
                if (state == S_PUSH_HI) begin
                    MemWData = hi_word;
                end else if (state == S_PUSH_LO) begin
                    MemWData = pc_q[15:0];
                end else begin
                    MemWData = flg_word;
                end
                if (MemAck) begin
                    SpWe   = 1'b1;
                    SpNext = SpIn - 16'd1;
                end
            end
            S_VEC_RD: begin
                MemReq  = 1'b1;
                MemAddr = VEC_ADDR;
                if (MemAck) begin
                    PcLoad      = 1'b1;
                    PcOut[15:0] = MemRData;
                end
            end
            S_POP_FLG, S_POP_LO, S_POP_HI: begin
                MemReq  = 1'b1;
                MemAddr = SpIn + 16'd1;
                if (MemAck) begin
                    SpWe   = 1'b1;
                    SpNext = SpIn + 16'd1;
                end
                // Final pop restores PC and flags together.
                if (pop_hi_ack) begin
                    PcLoad    = 1'b1;
                    PcOut     = {MemRData[PC_W-17:0], lo_q};
                    FlagsLoad = 1'b1;
                    FlagsOut  = flg_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Bench for int_sequencer: a memory/SP responder plus a frame-stack model of interrupt entry and RTI return.
module tb_int_sequencer;

    logic        Clk = 1'b0;
    logic        Rst, Int, RtiReq, PipeDrained, MemAck;
    logic [31:0] PcIn;
    logic [2:0]  FlagsIn;
    logic [15:0] SpIn, MemRData;
    logic        Busy, FlushIFID, MemReq, MemWe, SpWe, PcLoad, FlagsLoad;
    logic [15:0] MemAddr, MemWData, SpNext;
    logic [31:0] PcOut;
    logic [2:0]  FlagsOut;
`ifdef INT_MASK_EN
    logic        IntEnSet, IntEnClr, IntEn;
`endif

    always #5 Clk = ~Clk;

    int_sequencer #(.PC_W(32), .VEC_ADDR(16'h0002), .FLG_W(3)) dut (
        .Clk(Clk), .Rst(Rst), .Int(Int), .RtiReq(RtiReq), .PipeDrained(PipeDrained),
        .PcIn(PcIn), .FlagsIn(FlagsIn), .SpIn(SpIn), .MemAck(MemAck), .MemRData(MemRData),
`ifdef INT_MASK_EN
        .IntEnSet(IntEnSet), .IntEnClr(IntEnClr), .IntEn(IntEn),
`endif
        .Busy(Busy), .FlushIFID(FlushIFID), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemWData(MemWData), .SpWe(SpWe), .SpNext(SpNext),
        .PcLoad(PcLoad), .PcOut(PcOut), .FlagsLoad(FlagsLoad), .FlagsOut(FlagsOut)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    int          flush_n = 0;
    int          busy_n = 0;
    int          req_n = 0;
    int          ack_wait = 0;
    bit          ack_rand = 0;
    bit          rand_drain = 0;
    bit          log_stall = 0;
    logic [15:0] mem [65536];
    logic [15:0] vec;
    logic [15:0] msp;
    logic [31:0] ev_pc[$];
    logic [2:0]  ev_fl[$];
    logic        ev_fload[$];
    int          ev_cyc[$];
    logic [15:0] st_addr[$];
    logic [15:0] st_dat[$];
    logic        st_spwe[$];
    logic [31:0] fr_pc[$];
    logic [2:0]  fr_fl[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: act as memory and SP register, log what the DUT does.
    task automatic cyc();
        logic [15:0] sp_nx;
        @(negedge Clk);
        MemAck   = 1'b0;
        MemRData = 16'h0;
        if (rand_drain) PipeDrained = ($urandom_range(0, 3) != 0);
        #1;
        if (MemReq) begin
            if (ack_wait > 0) begin
                ack_wait--;
            end else begin
                MemAck = ack_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (!MemWe) MemRData = mem[MemAddr];
        end
        #1;
        if (log_stall && MemReq && !MemAck) begin
            st_addr.push_back(MemAddr);
            st_dat.push_back(MemWData);
            st_spwe.push_back(SpWe);
        end
        if (Busy) busy_n++;
        if (MemReq) req_n++;
        if (FlushIFID) flush_n++;
        if (MemReq && MemAck && MemWe) mem[MemAddr] = MemWData;
        sp_nx = SpWe ? SpNext : SpIn;
        if (PcLoad) begin
            ev_pc.push_back(PcOut);
            ev_fl.push_back(FlagsOut);
            ev_fload.push_back(FlagsLoad);
            ev_cyc.push_back(cyc_n);
        end
        @(posedge Clk);
        #1;
        SpIn = sp_nx;
        cyc_n++;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k = 0;
        while (ev_pc.size() < n && k < budget) begin
            cyc();
            k++;
        end
        chk({tag, "_done"}, 32'(ev_pc.size() >= n), 32'd1);
    endtask

    task automatic chk_frame(input string tag, input logic [15:0] s0, input logic [31:0] pc, input logic [2:0] fl);
        logic [15:0] a1, a2;
        a1 = s0 - 16'd1;
        a2 = s0 - 16'd2;
        chk({tag, "_mhi"}, 32'(mem[s0]), 32'(pc[31:16]));
        chk({tag, "_mlo"}, 32'(mem[a1]), 32'(pc[15:0]));
        chk({tag, "_mfl"}, 32'(mem[a2]), {29'd0, fl});
    endtask

    // Interrupt entry expected: frame {pc_hi, pc_lo, flags} below SP, SP-3, PC <- vector.
    task automatic finish_int(input string tag, input int base, input int c0, input bit lat_chk);
        run_until(base + 1, 300, tag);
        if (ev_pc.size() > base) begin
            if (lat_chk) chk({tag, "_lat"}, 32'(ev_cyc[base] - c0), 32'd6);
            chk({tag, "_vec"}, ev_pc[base], {16'h0, vec});
            chk({tag, "_fld"}, 32'(ev_fload[base]), 32'd0);
        end
        chk_frame(tag, msp, PcIn, FlagsIn);
        fr_pc.push_back(PcIn);
        fr_fl.push_back(FlagsIn);
        msp = msp - 16'd3;
        chk({tag, "_sp"}, 32'(SpIn), 32'(msp));
    endtask

    task automatic service_int(input string tag, input bit lat_chk);
        int base, c0;
        base = ev_pc.size();
        c0 = cyc_n;
        Int = 1'b1;
        cyc();
        Int = 1'b0;
        finish_int(tag, base, c0, lat_chk);
    endtask

    task automatic finish_rti(input string tag, input int base, input int r0, input bit lat_chk);
        logic [31:0] epc;
        logic [2:0]  efl;
        epc = fr_pc.pop_back();
        efl = fr_fl.pop_back();
        run_until(base + 1, 300, tag);
        if (ev_pc.size() > base) begin
            if (lat_chk) chk({tag, "_lat"}, 32'(ev_cyc[base] - r0), 32'd3);
            chk({tag, "_pc"}, ev_pc[base], epc);
            chk({tag, "_fl"}, 32'(ev_fl[base]), 32'(efl));
            chk({tag, "_fld"}, 32'(ev_fload[base]), 32'd1);
        end
        msp = msp + 16'd3;
        chk({tag, "_sp"}, 32'(SpIn), 32'(msp));
    endtask

    task automatic service_rti(input string tag, input bit lat_chk);
        int base, r0;
        base = ev_pc.size();
        r0 = cyc_n;
        RtiReq = 1'b1;
        cyc();
        RtiReq = 1'b0;
        finish_rti(tag, base, r0, lat_chk);
    endtask

    initial begin
        int          f0, base, c0, k;
        logic [15:0] s0;
        Rst = 1'b1; Int = 1'b0; RtiReq = 1'b0; PipeDrained = 1'b1; MemAck = 1'b0;
        PcIn = 32'h0; FlagsIn = 3'h0; SpIn = 16'h07FF; MemRData = 16'h0;
`ifdef INT_MASK_EN
        IntEnSet = 1'b0; IntEnClr = 1'b0;
`endif
        repeat (3) cyc();
        Rst = 1'b0;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_req", 32'(MemReq), 32'd0);
        chk("rst_spwe", 32'(SpWe), 32'd0);
        chk("rst_pcld", 32'(PcLoad), 32'd0);
        chk("rst_flush", 32'(FlushIFID), 32'd0);
        chk("rst_flld", 32'(FlagsLoad), 32'd0);
        chk("rst_addr", 32'(MemAddr), 32'd0);
        chk("rst_pcout", PcOut, 32'd0);

        // Directed entry and return.
        vec = 16'h0100; mem[2] = vec;
        PcIn = 32'h0001_2345; FlagsIn = 3'b101; SpIn = 16'h07FF; msp = 16'h07FF;
        f0 = flush_n;
        service_int("int", 1'b1);
        chk("int_flush", 32'(flush_n - f0), 32'd1);
        service_rti("rti", 1'b1);

        // Memory stall during PUSH_HI.
        s0 = msp;
        ack_wait = 3; log_stall = 1'b1;
        st_addr.delete(); st_dat.delete(); st_spwe.delete();
        service_int("stall", 1'b0);
        log_stall = 1'b0;
        chk("stall_n", 32'(st_addr.size()), 32'd3);
        for (int i = 0; i < st_addr.size(); i++) begin
            chk("stall_addr", 32'(st_addr[i]), 32'(s0));
            chk("stall_dat", 32'(st_dat[i]), 32'(PcIn[31:16]));
            chk("stall_spwe", 32'(st_spwe[i]), 32'd0);
        end

        // Pipe not drained for 4 cycles, second edge arrives meanwhile.
        PcIn = 32'h0000_BEEF; FlagsIn = 3'b010;
        PipeDrained = 1'b0;
        base = ev_pc.size(); f0 = flush_n;
        Int = 1'b1; cyc(); Int = 1'b0;
        busy_n = 0; req_n = 0;
        cyc();
        Int = 1'b1; cyc(); Int = 1'b0;
        repeat (3) cyc();
        chk("drain_busy", 32'(busy_n), 32'd4);
        chk("drain_req", 32'(req_n), 32'd0);
        PipeDrained = 1'b1;
        finish_int("drain1", base, 0, 1'b0);
        finish_int("drain2", base + 1, 0, 1'b0);
        chk("drain_flush", 32'(flush_n - f0), 32'd2);

        // RTI and pending in the same IDLE cycle: RTI first.
        PcIn = 32'h0000_7777; FlagsIn = 3'b001;
        base = ev_pc.size();
        Int = 1'b1; cyc(); Int = 1'b0;
        RtiReq = 1'b1; cyc(); RtiReq = 1'b0;
        finish_rti("prio_rti", base, 0, 1'b0);
        finish_int("prio_int", base + 1, 0, 1'b0);

        // Reset in PUSH_LO aborts; a later edge starts fresh.
        SpIn = 16'h0400; msp = 16'h0400; fr_pc.delete(); fr_fl.delete();
        Int = 1'b1; cyc(); Int = 1'b0;
        repeat (3) cyc();
        chk("mid_in_lo", 32'(MemWData), 32'(PcIn[15:0]));
        Rst = 1'b1; cyc(); Rst = 1'b0;
        chk("mid_busy", 32'(Busy), 32'd0);
        chk("mid_req", 32'(MemReq), 32'd0);
        chk("mid_spwe", 32'(SpWe), 32'd0);
        SpIn = 16'h0600; msp = 16'h0600;
        service_int("fresh", 1'b1);
        service_rti("fresh_rti", 1'b1);

        // SP wrap in both directions.
        SpIn = 16'h0001; msp = 16'h0001; fr_pc.delete(); fr_fl.delete();
        PcIn = 32'h0000_ABCD; FlagsIn = 3'b110;
        service_int("wrap", 1'b1);
        service_rti("wrap_rti", 1'b1);

        // Randomized nesting, memory waits and drain delays.
        ack_rand = 1'b1; rand_drain = 1'b1;
        for (int it = 0; it < 16; it++) begin
            fr_pc.delete(); fr_fl.delete();
            msp = 16'($urandom_range(16'h0100, 16'hFF00));
            SpIn = msp;
            vec = 16'($urandom); mem[2] = vec;
            for (int j = 0; j < 6; j++) mem[16'(msp - 16'(j))] = 16'($urandom);
            k = $urandom_range(1, 2);
            for (int j = 0; j < k; j++) begin
                PcIn = $urandom;
                FlagsIn = 3'($urandom);
                service_int("rnd_int", 1'b0);
            end
            for (int j = 0; j < k; j++) service_rti("rnd_rti", 1'b0);
        end
        ack_rand = 1'b0; rand_drain = 1'b0; PipeDrained = 1'b1;

`ifdef INT_MASK_EN
        // Masked edge is held until enabled again.
        SpIn = 16'h0700; msp = 16'h0700; fr_pc.delete(); fr_fl.delete();
        vec = 16'h0200; mem[2] = vec;
        IntEnClr = 1'b1; cyc(); IntEnClr = 1'b0;
        chk("mask_clr", 32'(IntEn), 32'd0);
        base = ev_pc.size();
        Int = 1'b1; cyc(); Int = 1'b0;
        repeat (8) cyc();
        chk("mask_held", 32'(ev_pc.size() - base), 32'd0);
        chk("mask_busy", 32'(Busy), 32'd0);
        IntEnSet = 1'b1; cyc(); IntEnSet = 1'b0;
        finish_int("mask_int", base, 0, 1'b0);
        chk("mask_en_off", 32'(IntEn), 32'd0);
        service_rti("mask_rti", 1'b0);
        chk("mask_en_on", 32'(IntEn), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
